// File: rtl/sector_cache_ctrl.sv
// Set-associative, sectored cache tag/valid controller.
// Classifies each access as hit / sector miss / line miss, tracks per-sector
// valid bits and true-LRU ages per set, and issues sector or line fills.
module sector_cache_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int LINE_SIZE   = 32,
    parameter int SECTOR_SIZE = 4,
    parameter int ASSOC       = 4,
    parameter int NUM_SETS    = 64,
    parameter int FILL_MODE   = 0,
    parameter int CNT_W       = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic [ADDR_W-1:0]                       req_addr,
    output logic                                    rsp_valid,
    output logic [1:0]                              rsp_kind,
    output logic [$clog2(ASSOC)-1:0]                rsp_way,
    output logic                                    mem_req_valid,
    output logic [ADDR_W-1:0]                       mem_req_addr,
    output logic [$clog2(LINE_SIZE/SECTOR_SIZE):0]  mem_req_len,
    input  logic                                    mem_ack,
    input  logic                                    clear_stats,
    output logic [CNT_W-1:0]                        total_hits,
    output logic [CNT_W-1:0]                        total_sector_misses,
    output logic [CNT_W-1:0]                        total_line_misses,
    output logic [CNT_W-1:0]                        total_evictions
);
    localparam int OFF_W   = $clog2(LINE_SIZE);
    localparam int SOFF_W  = $clog2(SECTOR_SIZE);
    localparam int SECTORS = LINE_SIZE / SECTOR_SIZE;
    localparam int SET_W   = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDR_W - OFF_W - SET_W;
    localparam int WAY_W   = $clog2(ASSOC);
    localparam int LEN_W   = $clog2(SECTORS) + 1;

    localparam logic [1:0] K_HIT = 2'd0, K_SMISS = 2'd1, K_LMISS = 2'd2;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;
    state_t state_q, state_d;

    // Tag/valid/LRU storage, one entry per set and way
    logic [TAG_W-1:0]   tag_q [NUM_SETS][ASSOC];
    logic [TAG_W-1:0]   tag_d [NUM_SETS][ASSOC];
    logic               lv_q  [NUM_SETS][ASSOC];
    logic               lv_d  [NUM_SETS][ASSOC];
    logic [SECTORS-1:0] sv_q  [NUM_SETS][ASSOC];
    logic [SECTORS-1:0] sv_d  [NUM_SETS][ASSOC];
    logic [WAY_W-1:0]   age_q [NUM_SETS][ASSOC];
    logic [WAY_W-1:0]   age_d [NUM_SETS][ASSOC];

    logic [ADDR_W-1:0] addr_q, addr_d, maddr_q, maddr_d;
    logic [1:0]        kind_q, kind_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [LEN_W-1:0]  mlen_q, mlen_d;
    logic [CNT_W-1:0]  hits_q, hits_d, smiss_q, smiss_d, lmiss_q, lmiss_d, evict_q, evict_d;

    // Decoded fields of the captured request
    logic [SET_W-1:0]   set_idx;
    logic [TAG_W-1:0]   tag_in;
    logic [SECTORS-1:0] sec_bit;
    assign set_idx = addr_q[OFF_W +: SET_W];
    assign tag_in  = addr_q[ADDR_W-1 -: TAG_W];
    assign sec_bit = SECTORS'(1) << ((addr_q >> SOFF_W) & ADDR_W'(SECTORS - 1));

    logic             match, sec_hit, vic_valid;
    logic [WAY_W-1:0] hit_way, vic_way, lk_way;
    logic [1:0]       lk_kind;

    // Tag compare and victim selection for the captured request
    always_comb begin
        match   = 1'b0;
        hit_way = '0;
        vic_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (!match && lv_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
                match   = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Oldest way first, then any invalid way overrides; descending loop keeps the lowest index
        for (int w = ASSOC - 1; w >= 0; w--)
            if (age_q[set_idx][w] == WAY_W'(ASSOC - 1)) vic_way = WAY_W'(w);
        for (int w = ASSOC - 1; w >= 0; w--)
            if (!lv_q[set_idx][w]) vic_way = WAY_W'(w);
        vic_valid = lv_q[set_idx][vic_way];
        sec_hit   = |(sv_q[set_idx][hit_way] & sec_bit);
        lk_kind   = !match ? K_LMISS : (sec_hit ? K_HIT : K_SMISS);
        lk_way    = match ? hit_way : vic_way;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = LOOKUP;
            LOOKUP:  state_d = (lk_kind == K_HIT) ? RESP : FILL;
            FILL:    if (mem_ack) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready     = (state_q == IDLE);
        rsp_valid     = (state_q == RESP);
        mem_req_valid = (state_q == FILL);
        rsp_kind      = rsp_valid ? kind_q : 2'd0;
        rsp_way       = way_q;
        mem_req_addr  = maddr_q;
        mem_req_len   = mlen_q;
    end

    logic             touch;
    logic [WAY_W-1:0] touch_way, old_age;

    // Request capture, lookup result, fill write and LRU update
    always_comb begin
        tag_d     = tag_q;
        lv_d      = lv_q;
        sv_d      = sv_q;
        age_d     = age_q;
        addr_d    = addr_q;
        kind_d    = kind_q;
        way_d     = way_q;
        maddr_d   = maddr_q;
        mlen_d    = mlen_q;
        touch     = 1'b0;
        touch_way = way_q;
        old_age   = '0;
        case (state_q)
            IDLE: if (req_valid) addr_d = req_addr;
            LOOKUP: begin
                kind_d = lk_kind;
                way_d  = lk_way;
                if (lk_kind == K_HIT) begin
                    touch     = 1'b1;
                    touch_way = lk_way;
                end
                maddr_d = (FILL_MODE != 0) ? (addr_q & ~ADDR_W'(LINE_SIZE - 1))
                                           : (addr_q & ~ADDR_W'(SECTOR_SIZE - 1));
                mlen_d  = (FILL_MODE != 0) ? LEN_W'(SECTORS) : LEN_W'(1);
            end
            FILL: if (mem_ack) begin
                tag_d[set_idx][way_q] = tag_in;
                lv_d[set_idx][way_q]  = 1'b1;
                // A freshly allocated line drops whatever sectors the victim held
                sv_d[set_idx][way_q]  = ((kind_q == K_LMISS) ? '0 : sv_q[set_idx][way_q])
                                      | ((FILL_MODE != 0) ? '1 : sec_bit);
                touch     = 1'b1;
                touch_way = way_q;
            end
            default: ;
        endcase
        if (touch) begin
            old_age = age_q[set_idx][touch_way];
            for (int w = 0; w < ASSOC; w++) begin
                if (WAY_W'(w) == touch_way)          age_d[set_idx][w] = '0;
                else if (age_q[set_idx][w] < old_age) age_d[set_idx][w] = age_q[set_idx][w] + 1'b1;
            end
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Statistics: saturating, clear wins over a same-cycle increment
    always_comb begin
        hits_d  = hits_q;
        smiss_d = smiss_q;
        lmiss_d = lmiss_q;
        evict_d = evict_q;
        if (state_q == RESP) begin
            case (kind_q)
                K_HIT:   hits_d  = sat_inc(hits_q);
                K_SMISS: smiss_d = sat_inc(smiss_q);
                default: lmiss_d = sat_inc(lmiss_q);
            endcase
        end
        if (state_q == LOOKUP && lk_kind == K_LMISS && vic_valid) evict_d = sat_inc(evict_q);
        if (clear_stats) begin
            hits_d  = '0;
            smiss_d = '0;
            lmiss_d = '0;
            evict_d = '0;
        end
    end

    assign total_hits          = hits_q;
    assign total_sector_misses = smiss_q;
    assign total_line_misses   = lmiss_q;
    assign total_evictions     = evict_q;

    // Datapath and storage registers; reset wipes every entry in one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    tag_q[s][w] <= '0;
                    lv_q[s][w]  <= 1'b0;
                    sv_q[s][w]  <= '0;
                    age_q[s][w] <= WAY_W'(w);
                end
            end
            addr_q  <= '0;
            kind_q  <= K_HIT;
            way_q   <= '0;
            maddr_q <= '0;
            mlen_q  <= '0;
            hits_q  <= '0;
            smiss_q <= '0;
            lmiss_q <= '0;
            evict_q <= '0;
        end else begin
            tag_q   <= tag_d;
            lv_q    <= lv_d;
            sv_q    <= sv_d;
            age_q   <= age_d;
            addr_q  <= addr_d;
            kind_q  <= kind_d;
            way_q   <= way_d;
            maddr_q <= maddr_d;
            mlen_q  <= mlen_d;
            hits_q  <= hits_d;
            smiss_q <= smiss_d;
            lmiss_q <= lmiss_d;
            evict_q <= evict_d;
        end
    end
endmodule

// File: tb/tb_sector_cache_ctrl.sv
// Bench for sector_cache_ctrl: dut 0 uses sector fills and 32-bit counters,
// dut 1 uses whole-line fills and 2-bit counters. Expected results come from
// a recency-list model of each cache.
module tb_sector_cache_ctrl;
    localparam int NS = 64, AS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       req_valid = '0, mem_ack = '0, clear_stats = '0;
    logic [1:0][31:0] req_addr = '0;
    logic [1:0]       req_ready, rsp_valid, mem_req_valid;
    logic [1:0][1:0]  rsp_kind, rsp_way;
    logic [1:0][31:0] maddr;
    logic [1:0][3:0]  mlen;
    logic [3:0][31:0] cnt0;
    logic [3:0][1:0]  cnt1;

    sector_cache_ctrl #(.FILL_MODE(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_kind(rsp_kind[0]),
        .rsp_way(rsp_way[0]), .mem_req_valid(mem_req_valid[0]), .mem_req_addr(maddr[0]),
        .mem_req_len(mlen[0]), .mem_ack(mem_ack[0]), .clear_stats(clear_stats[0]),
        .total_hits(cnt0[0]), .total_sector_misses(cnt0[1]),
        .total_line_misses(cnt0[2]), .total_evictions(cnt0[3]));

    sector_cache_ctrl #(.FILL_MODE(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_kind(rsp_kind[1]),
        .rsp_way(rsp_way[1]), .mem_req_valid(mem_req_valid[1]), .mem_req_addr(maddr[1]),
        .mem_req_len(mlen[1]), .mem_ack(mem_ack[1]), .clear_stats(clear_stats[1]),
        .total_hits(cnt1[0]), .total_sector_misses(cnt1[1]),
        .total_line_misses(cnt1[2]), .total_evictions(cnt1[3]));

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt(input int d, input int k);
        return (d == 0) ? cnt0[k] : {30'b0, cnt1[k]};
    endfunction

    // Model: per set, valid/tag/sector mask per way plus a recency list (index 0 = MRU)
    bit          m_v   [2][NS][AS];
    int unsigned m_tag [2][NS][AS];
    bit [7:0]    m_sv  [2][NS][AS];
    int          m_ord [2][NS][AS];
    int unsigned m_cnt [2][4];
    int unsigned cmax  [2] = '{32'hffff_ffff, 3};

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < AS; w++) begin
                    m_v[d][s][w] = 0; m_sv[d][s][w] = 0; m_tag[d][s][w] = 0; m_ord[d][s][w] = w;
                end
        end
    endfunction

    function automatic void m_touch(input int d, input int s, input int w);
        int p = 0;
        for (int i = 0; i < AS; i++) if (m_ord[d][s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_ord[d][s][i] = m_ord[d][s][i-1];
        m_ord[d][s][0] = w;
    endfunction

    function automatic void m_inc(input int d, input int k);
        if (m_cnt[d][k] < cmax[d]) m_cnt[d][k]++;
    endfunction

    // One access on dut d; ck/cw are extra plan-fixed expectations (-1 = none)
    task automatic access(input int d, input logic [31:0] a, input int dly, input bit clr,
                          input int ck, input int cw);
        int s, t, sec, ek, ew, n, f, ackc, fst;
        bit found;
        logic [31:0] ea, el;
        s = int'((a >> 5) & 32'd63); t = int'(a >> 11); sec = int'((a >> 2) & 32'd7);
        found = 0; ew = 0;
        for (int w = 0; w < AS; w++)
            if (!found && m_v[d][s][w] && m_tag[d][s][w] == t) begin found = 1; ew = w; end
        if (found) ek = m_sv[d][s][ew][sec] ? 0 : 1;
        else begin
            ek = 2;
            ew = m_ord[d][s][AS-1];
            for (int w = AS - 1; w >= 0; w--) if (!m_v[d][s][w]) ew = w;
            if (m_v[d][s][ew]) m_inc(d, 3);
        end
        ea = (d == 1) ? (a & ~32'd31) : (a & ~32'd3);
        el = (d == 1) ? 32'd8 : 32'd1;

        n = 0;
        while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
        chk("ready_idle", {31'b0, req_ready[d]}, 32'd1);
        req_valid[d] = 1'b1; req_addr[d] = a;
        @(negedge clk);
        req_valid[d] = 1'b0;
        n = 1; f = 0; ackc = -1; fst = -1;
        while (!rsp_valid[d] && n < 60) begin
            if (mem_req_valid[d]) begin
                if (fst < 0) fst = n;
                chk("fill_addr", maddr[d], ea);
                chk("fill_len", {28'b0, mlen[d]}, el);
                chk("ready_in_fill", {31'b0, req_ready[d]}, 32'd0);
                if (f == dly) begin mem_ack[d] = 1'b1; ackc = n; end
                f++;
            end
            @(negedge clk);
            mem_ack[d] = 1'b0;
            n++;
        end
        chk("rsp_seen", {31'b0, rsp_valid[d]}, 32'd1);
        chk("rsp_kind", {30'b0, rsp_kind[d]}, 32'(ek));
        chk("rsp_way", {30'b0, rsp_way[d]}, 32'(ew));
        if (ek == 0) chk("hit_latency", 32'(n), 32'd2);
        else begin
            chk("fill_start", 32'(fst), 32'd2);
            chk("ack_to_rsp", 32'(n), 32'(ackc + 1));
        end
        if (ck >= 0) chk("plan_kind", {30'b0, rsp_kind[d]}, 32'(ck));
        if (cw >= 0) chk("plan_way", {30'b0, rsp_way[d]}, 32'(cw));
        if (clr) clear_stats[d] = 1'b1;

        if (ek != 0) begin
            if (ek == 2) m_sv[d][s][ew] = 0;
            m_tag[d][s][ew] = t;
            m_v[d][s][ew] = 1;
            m_sv[d][s][ew] = m_sv[d][s][ew] | ((d == 1) ? 8'hff : (8'h1 << sec));
        end
        m_touch(d, s, ew);
        if (clr) for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
        else m_inc(d, ek);

        @(negedge clk);
        clear_stats[d] = 1'b0;
        chk("rsp_one_cycle", {31'b0, rsp_valid[d]}, 32'd0);
        chk("cnt_hits", cnt(d, 0), m_cnt[d][0]);
        chk("cnt_smiss", cnt(d, 1), m_cnt[d][1]);
        chk("cnt_lmiss", cnt(d, 2), m_cnt[d][2]);
        chk("cnt_evict", cnt(d, 3), m_cnt[d][3]);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_reset();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", {31'b0, req_ready[d]}, 32'd1);
            chk("rst_rsp_valid", {31'b0, rsp_valid[d]}, 32'd0);
            chk("rst_mem_valid", {31'b0, mem_req_valid[d]}, 32'd0);
            chk("rst_kind", {30'b0, rsp_kind[d]}, 32'd0);
            for (int k = 0; k < 4; k++) chk("rst_cnt", cnt(d, k), 32'd0);
        end
    endtask

    // Reset dut 0 in the middle of a fill, then send a late ack
    task automatic reset_mid_fill(input logic [31:0] a);
        req_valid[0] = 1'b1; req_addr[0] = a;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("fill_before_rst", {31'b0, mem_req_valid[0]}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("fill_dropped", {31'b0, mem_req_valid[0]}, 32'd0);
        chk("ready_after_rst", {31'b0, req_ready[0]}, 32'd1);
        mem_ack[0] = 1'b1;
        @(negedge clk);
        mem_ack[0] = 1'b0;
        chk("late_ack_ignored", {31'b0, rsp_valid[0]}, 32'd0);
        m_reset();
        access(0, a, 1, 0, 2, -1);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // cold miss, sector miss, then hit
        access(0, 32'h4, 1, 0, 2, 0);
        access(0, 32'h8, 0, 0, 1, 0);
        access(0, 32'h8, 0, 0, 0, 0);
        chk("plan_hits", cnt(0, 0), 32'd1);

        // set-0 conflicts and LRU eviction
        do_reset();
        access(0, 32'h0,    0, 0, 2, 0);
        access(0, 32'h800,  1, 0, 2, 1);
        access(0, 32'h1000, 2, 0, 2, 2);
        access(0, 32'h1800, 0, 0, 2, 3);
        access(0, 32'h0,    0, 0, 0, 0);
        access(0, 32'h2000, 0, 0, 2, 1);
        chk("plan_evictions", cnt(0, 3), 32'd1);

        // long fill stall
        access(0, 32'h3004, 10, 0, 2, -1);

        reset_mid_fill(32'h4000);

        // clear during a hit response
        access(0, 32'h4000, 0, 1, 0, -1);
        for (int k = 0; k < 4; k++) chk("cleared", cnt(0, k), 32'd0);

        // whole-line fill and saturating 2-bit counter
        access(1, 32'h14, 2, 0, 2, 0);
        chk("plan_line_addr", maddr[1], 32'h0);
        access(1, 32'h1C, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) access(1, 32'h1C, 0, 0, 0, 0);
        chk("plan_sat_hits", cnt(1, 0), 32'd3);

        // random traffic over a small tag/set pool
        for (int i = 0; i < 300; i++) begin
            int d;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 5) << 11) | ($urandom_range(0, 3) << 5)
              | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            access(d, a, int'($urandom_range(0, 4)), ($urandom_range(0, 19) == 0), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sector_cache_ctrl.md
# sector_cache_ctrl

Parametrised, set-associative, sectored cache tag/valid controller. It sits between an address-trace source (request handshake) and a backing-memory model (fill handshake). It classifies each access as hit, sector miss or line miss, keeps true-LRU state per set and supports single-sector or whole-line fill. It holds no data array; it is the timing-accurate successor of the one-address-per-cycle hit/miss model, and it adds fill stalls, sector-valid tracking, LRU and eviction statistics.

## Interface
- ADDR_W, 32, address width
- LINE_SIZE, 32, bytes per line (power of 2)
- SECTOR_SIZE, 4, bytes per sector (power of 2, ≤ LINE_SIZE); SECTORS = LINE_SIZE/SECTOR_SIZE
- ASSOC, 4, ways per set (power of 2, ≥ 2)
- NUM_SETS, 64, sets (power of 2)
- FILL_MODE, 0, 0 = fill the missing sector only, 1 = fill the whole line
- CNT_W, 32, statistics counter width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  access request
- req_ready  out  1  controller can accept a request
- req_addr  in  ADDR_W  byte address
- rsp_valid  out  1  one-cycle result pulse
- rsp_kind  out  2  0 = hit, 1 = sector miss, 2 = line miss
- rsp_way  out  log2(ASSOC)  way hit or allocated
- mem_req_valid  out  1  fill request, held until acknowledged
- mem_req_addr  out  ADDR_W  fill base address, sector- or line-aligned
- mem_req_len  out  log2(SECTORS)+1  sectors requested
- mem_ack  in  1  fill complete (single-cycle pulse)
- clear_stats  in  1  zero all statistics counters
- total_hits, total_sector_misses, total_line_misses, total_evictions  out  CNT_W each  statistics

## Operation
- Address split:
  - offset = addr[log2(LINE_SIZE)-1:0]
  - sector = addr[log2(LINE_SIZE)-1:log2(SECTOR_SIZE)]
  - set = the next log2(NUM_SETS) bits
  - tag = the remaining upper bits
- Per way/set state: tag, line_valid, sector_valid[SECTORS], age[log2(ASSOC)].
- FSM IDLE → LOOKUP → (RESP | FILL → RESP) → IDLE.
  - req_ready = 1 only in IDLE.
  - The request is captured on the edge where req_valid && req_ready.
- LOOKUP compares all ways and registers the outcome:
  - Hit: line_valid, tag match and sector_valid set.
  - Sector miss: line_valid and tag match, sector_valid clear.
  - Line miss: no way matches.
- Hit: go to RESP. Update LRU: touched way age = 0; ways with age < old age increment.
- Sector miss: go to FILL.
  - Mode 0: mem_req_addr = sector-aligned address, len = 1.
  - Mode 1: line-aligned address, len = SECTORS.
- Line miss: choose the victim, then go to FILL.
  - Victim is the lowest-index invalid way; otherwise the way with age = ASSOC-1.
  - If the victim was line_valid, total_evictions increments.
- FILL: mem_req_valid is held high with stable address and length until mem_ack. On mem_ack:
  - Write the tag and set line_valid.
  - Set sector_valid: the requested sector only (mode 0) or all bits (mode 1).
  - On a line miss, clear the victim's other sector bits first.
  - Update LRU; go to RESP.
- RESP: rsp_valid = 1 for one cycle with rsp_kind and rsp_way. The matching counter increments in the same cycle. Next state is IDLE.
- Counters saturate at 2^CNT_W-1.
- clear_stats zeroes all four counters. It wins over a simultaneous increment, and that event is not counted.

## Timing
- Reset (rst = 0 at an edge):
  - Next state IDLE.
  - All line_valid and sector_valid bits are cleared.
  - age[w] = w in every set.
  - Counters are 0; req_ready = 1; rsp_valid, mem_req_valid and rsp_kind are 0.
  - Clearing NUM_SETS×ASSOC entries happens in one cycle (flop array).
- Hit latency: captured at edge 0, LOOKUP at cycle 1, rsp_valid at cycle 2. req_ready rises at cycle 3. Throughput is one access per 3 cycles.
- Miss latency:
  - mem_req_valid is asserted from cycle 2.
  - If mem_ack is sampled at edge k, rsp_valid is high in cycle k+1.
  - mem_ack is ignored outside FILL.
- Reset during FILL: mem_req_valid is 0 on the next cycle and the pending fill is abandoned. A late mem_ack is ignored.
- A request whose address matches the line just filled is evaluated against the updated state; there is no stale bypass.
- ASSOC ages remain a permutation of 0..ASSOC-1 at all times.

## Test plan
- Cold access 0x0000_0004 after reset → rsp_kind = 2, way 0, mem_req_addr = 0x4, len = 1, total_line_misses = 1, total_evictions = 0.
- Then 0x0000_0008 (same line, sector 2) → kind 1, len = 1. Repeating 0x0000_0008 → kind 0, rsp_valid exactly 2 cycles after acceptance, total_hits = 1.
- Conflicting addresses 0x0, 0x800, 0x1000, 0x1800 (set 0), then re-hit 0x0, then 0x2000 → ways 0..3 allocated, then 0x800's way (1) evicted, total_evictions = 1.
- FILL_MODE = 1: line miss at 0x0000_0014 → mem_req_addr = 0x0, len = 8. A later 0x0000_001C → hit.
- mem_ack delayed 10 cycles → mem_req_valid and the address stay stable for all 10 cycles, req_ready = 0 throughout. rst asserted mid-FILL → mem_req_valid = 0 next cycle, and the next access to the same address is a line miss.
- clear_stats pulsed in the same cycle as a hit rsp_valid → all counters read 0 afterwards. With CNT_W = 2, five hits → total_hits = 3 (saturated).
